// File: rtl/audio_controller.sv
// audio_controller: stereo PCM bridge between fabric-side FIFOs and a codec that
// masters BCLK and both LRCKs; left-justified framing, MSB first.
module audio_controller #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned XCK_DIV    = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_in_memory,
    input  logic                  read_audio_in,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    input  logic                  AUD_ADCDAT,
    inout  wire                   AUD_BCLK,
    inout  wire                   AUD_ADCLRCK,
    inout  wire                   AUD_DACLRCK,
    output logic                  audio_in_available,
    output logic [DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                  audio_out_allowed,
    output logic                  AUD_XCK,
    output logic                  AUD_DACDAT
);

    localparam int unsigned PAIR_W = 2 * DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int unsigned XCK_W  = (XCK_DIV > 1) ? $clog2(XCK_DIV) : 1;

    // Reset: asserts asynchronously, releases on a clock edge
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // Pin synchronisers plus a previous-value stage for edge detection
    logic [2:0] bclk_q;
    logic [2:0] adclr_q;
    logic [2:0] daclr_q;
    logic [1:0] adcdat_q;
    logic [1:0] prime_q;
    logic       edges_ok;
    logic       bclk_rise_q, bclk_fall_q;
    logic       adc_lr_rise_q, adc_lr_fall_q;
    logic       dac_lr_rise_q, dac_lr_fall_q;

    // Edges are ignored until the previous-value stage holds a real pin sample
    assign edges_ok = (prime_q == 2'd3);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q        <= '0;
            adclr_q       <= '0;
            daclr_q       <= '0;
            adcdat_q      <= '0;
            prime_q       <= '0;
            bclk_rise_q   <= 1'b0;
            bclk_fall_q   <= 1'b0;
            adc_lr_rise_q <= 1'b0;
            adc_lr_fall_q <= 1'b0;
            dac_lr_rise_q <= 1'b0;
            dac_lr_fall_q <= 1'b0;
        end else begin
            bclk_q        <= {bclk_q[1:0], AUD_BCLK};
            adclr_q       <= {adclr_q[1:0], AUD_ADCLRCK};
            daclr_q       <= {daclr_q[1:0], AUD_DACLRCK};
            adcdat_q      <= {adcdat_q[0], AUD_ADCDAT};
            if (!edges_ok) prime_q <= prime_q + 2'd1;
            bclk_rise_q   <= edges_ok &  bclk_q[1]  & ~bclk_q[2];
            bclk_fall_q   <= edges_ok & ~bclk_q[1]  &  bclk_q[2];
            adc_lr_rise_q <= edges_ok &  adclr_q[1] & ~adclr_q[2];
            adc_lr_fall_q <= edges_ok & ~adclr_q[1] &  adclr_q[2];
            dac_lr_rise_q <= edges_ok &  daclr_q[1] & ~daclr_q[2];
            dac_lr_fall_q <= edges_ok & ~daclr_q[1] &  daclr_q[2];
        end
    end

    // Codec master clock
    logic [XCK_W-1:0] xck_cnt_q;
    logic             xck_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            xck_cnt_q <= '0;
            xck_q     <= 1'b0;
        end else if (xck_cnt_q == XCK_W'(XCK_DIV - 1)) begin
            xck_cnt_q <= '0;
            xck_q     <= ~xck_q;
        end else begin
            xck_cnt_q <= xck_cnt_q + XCK_W'(1);
        end
    end

    // ADC deserialiser
    logic [DATA_WIDTH-1:0] adc_shift_q, adc_shift_d;
    logic [BIT_W-1:0]      adc_bits_q, adc_bits_d;
    logic [DATA_WIDTH-1:0] adc_left_q, adc_left_d;
    logic                  adc_armed_q, adc_armed_d;
    logic                  adc_left_ok_q, adc_left_ok_d;
    logic                  in_push;

    always_comb begin
        adc_shift_d   = adc_shift_q;
        adc_bits_d    = adc_bits_q;
        adc_left_d    = adc_left_q;
        adc_armed_d   = adc_armed_q;
        adc_left_ok_d = adc_left_ok_q;
        in_push       = 1'b0;
        if (adc_lr_fall_q || adc_lr_rise_q) begin
            adc_shift_d = '0;
            adc_bits_d  = '0;
            adc_armed_d = 1'b1;
            if (adc_lr_fall_q) begin
                adc_left_d    = adc_shift_q;
                adc_left_ok_d = adc_armed_q && (adc_bits_q == BIT_W'(DATA_WIDTH));
            end else begin
                in_push       = adc_left_ok_q;
                adc_left_ok_d = 1'b0;
            end
        end else if (bclk_rise_q && adc_armed_q && (adc_bits_q != BIT_W'(DATA_WIDTH))) begin
            adc_shift_d = {adc_shift_q[DATA_WIDTH-2:0], adcdat_q[1]};
            adc_bits_d  = adc_bits_q + BIT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            adc_shift_q   <= '0;
            adc_bits_q    <= '0;
            adc_left_q    <= '0;
            adc_armed_q   <= 1'b0;
            adc_left_ok_q <= 1'b0;
        end else begin
            adc_shift_q   <= adc_shift_d;
            adc_bits_q    <= adc_bits_d;
            adc_left_q    <= adc_left_d;
            adc_armed_q   <= adc_armed_d;
            adc_left_ok_q <= adc_left_ok_d;
        end
    end

    // Input FIFO with a registered show-ahead head
    logic [PAIR_W-1:0] in_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  in_rd_q, in_rd_d, in_wr_q, in_wr_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic              in_full, in_do_push, in_do_pop;
    logic [PAIR_W-1:0] in_push_data, in_head_q, in_head_d;
    logic              in_avail_q;

    assign in_push_data = {adc_left_q, adc_shift_q};

    always_comb begin
        in_rd_d    = in_rd_q;
        in_wr_d    = in_wr_q;
        in_cnt_d   = in_cnt_q;
        in_full    = (in_cnt_q == CNT_W'(FIFO_DEPTH));
        in_do_pop  = read_audio_in && (in_cnt_q != '0) && !clear_audio_in_memory;
        in_do_push = in_push && (!in_full || in_do_pop) && !clear_audio_in_memory;
        if (clear_audio_in_memory) begin
            in_rd_d  = '0;
            in_wr_d  = '0;
            in_cnt_d = '0;
        end else begin
            if (in_do_push) in_wr_d = in_wr_q + PTR_W'(1);
            if (in_do_pop)  in_rd_d = in_rd_q + PTR_W'(1);
            if (in_do_push && !in_do_pop)      in_cnt_d = in_cnt_q + CNT_W'(1);
            else if (!in_do_push && in_do_pop) in_cnt_d = in_cnt_q - CNT_W'(1);
        end
        // A push into the slot that becomes the head bypasses the memory
        if (in_cnt_d == '0)                        in_head_d = '0;
        else if (in_do_push && (in_wr_q == in_rd_d)) in_head_d = in_push_data;
        else                                       in_head_d = in_mem_q[in_rd_d];
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) in_mem_q[i] <= '0;
            in_rd_q    <= '0;
            in_wr_q    <= '0;
            in_cnt_q   <= '0;
            in_head_q  <= '0;
            in_avail_q <= 1'b0;
        end else begin
            if (in_do_push) in_mem_q[in_wr_q] <= in_push_data;
            in_rd_q    <= in_rd_d;
            in_wr_q    <= in_wr_d;
            in_cnt_q   <= in_cnt_d;
            in_head_q  <= in_head_d;
            in_avail_q <= (in_cnt_d != '0);
        end
    end

    // Output FIFO
    logic [PAIR_W-1:0] out_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  out_rd_q, out_rd_d, out_wr_q, out_wr_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_full, out_do_push, out_do_pop;
    logic [PAIR_W-1:0] out_head;
    logic              out_allowed_q;

    assign out_head = out_mem_q[out_rd_q];

    always_comb begin
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        out_cnt_d   = out_cnt_q;
        out_full    = (out_cnt_q == CNT_W'(FIFO_DEPTH));
        out_do_pop  = dac_lr_rise_q && (out_cnt_q != '0) && !clear_audio_out_memory;
        out_do_push = write_audio_out && (!out_full || out_do_pop) && !clear_audio_out_memory;
        if (clear_audio_out_memory) begin
            out_rd_d  = '0;
            out_wr_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (out_do_push) out_wr_d = out_wr_q + PTR_W'(1);
            if (out_do_pop)  out_rd_d = out_rd_q + PTR_W'(1);
            if (out_do_push && !out_do_pop)      out_cnt_d = out_cnt_q + CNT_W'(1);
            else if (!out_do_push && out_do_pop) out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) out_mem_q[i] <= '0;
            out_rd_q      <= '0;
            out_wr_q      <= '0;
            out_cnt_q     <= '0;
            out_allowed_q <= 1'b1;
        end else begin
            if (out_do_push) out_mem_q[out_wr_q] <= {left_channel_audio_out, right_channel_audio_out};
            out_rd_q      <= out_rd_d;
            out_wr_q      <= out_wr_d;
            out_cnt_q     <= out_cnt_d;
            out_allowed_q <= (out_cnt_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // DAC serialiser: hold registers load on the LRCK edge, shifter one cycle later
    logic [DATA_WIDTH-1:0] dac_hold_l_q, dac_hold_l_d;
    logic [DATA_WIDTH-1:0] dac_hold_r_q, dac_hold_r_d;
    logic [DATA_WIDTH-1:0] dac_shift_q, dac_shift_d;
    logic [DATA_WIDTH-1:0] dac_word;
    logic [BIT_W-1:0]      dac_bits_q, dac_bits_d;
    logic                  dac_load_q, dac_load_d;
    logic                  dac_sel_l_q, dac_sel_l_d;
    logic                  dac_bit_q, dac_bit_d;

    always_comb begin
        dac_hold_l_d = dac_hold_l_q;
        dac_hold_r_d = dac_hold_r_q;
        dac_shift_d  = dac_shift_q;
        dac_bits_d   = dac_bits_q;
        dac_sel_l_d  = dac_sel_l_q;
        dac_bit_d    = dac_bit_q;
        dac_load_d   = dac_lr_rise_q || dac_lr_fall_q;
        dac_word     = dac_sel_l_q ? dac_hold_l_q : dac_hold_r_q;
        if (dac_lr_rise_q) begin
            dac_hold_l_d = out_do_pop ? out_head[PAIR_W-1:DATA_WIDTH] : '0;
            dac_hold_r_d = out_do_pop ? out_head[DATA_WIDTH-1:0]      : '0;
            dac_sel_l_d  = 1'b1;
        end else if (dac_lr_fall_q) begin
            dac_sel_l_d  = 1'b0;
        end
        if (dac_load_q) begin
            dac_bit_d   = dac_word[DATA_WIDTH-1];
            dac_shift_d = {dac_word[DATA_WIDTH-2:0], 1'b0};
            dac_bits_d  = BIT_W'(1);
        end else if (bclk_fall_q && !dac_lr_rise_q && !dac_lr_fall_q) begin
            if (dac_bits_q != BIT_W'(DATA_WIDTH)) begin
                dac_bit_d   = dac_shift_q[DATA_WIDTH-1];
                dac_shift_d = {dac_shift_q[DATA_WIDTH-2:0], 1'b0};
                dac_bits_d  = dac_bits_q + BIT_W'(1);
            end else begin
                dac_bit_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dac_hold_l_q <= '0;
            dac_hold_r_q <= '0;
            dac_shift_q  <= '0;
            dac_bits_q   <= '0;
            dac_load_q   <= 1'b0;
            dac_sel_l_q  <= 1'b0;
            dac_bit_q    <= 1'b0;
        end else begin
            dac_hold_l_q <= dac_hold_l_d;
            dac_hold_r_q <= dac_hold_r_d;
            dac_shift_q  <= dac_shift_d;
            dac_bits_q   <= dac_bits_d;
            dac_load_q   <= dac_load_d;
            dac_sel_l_q  <= dac_sel_l_d;
            dac_bit_q    <= dac_bit_d;
        end
    end

    assign audio_in_available     = in_avail_q;
    assign left_channel_audio_in  = in_head_q[PAIR_W-1:DATA_WIDTH];
    assign right_channel_audio_in = in_head_q[DATA_WIDTH-1:0];
    assign audio_out_allowed      = out_allowed_q;
    assign AUD_XCK                = xck_q;
    assign AUD_DACDAT             = dac_bit_q;

endmodule

// File: tb/tb_audio_controller.sv
// Directed bench for audio_controller: a codec model drives BCLK/LRCK/ADCDAT
// and decodes AUD_DACDAT; expected values are hand-computed constants.
module tb_audio_controller;

    logic        clk;
    logic        rst_n;
    logic        clr_in, rd_in, clr_out, wr_out;
    logic [31:0] l_out, r_out;
    logic        adcdat_r, bclk_r, lrck_r;
    wire         aud_bclk, aud_adclrck, aud_daclrck;
    logic        avail, allowed, aud_xck, aud_dacdat;
    logic [31:0] l_in, r_in;

    int checks = 0;
    int errors = 0;
    logic [31:0] dl, dr;
    logic [31:0] ovf_l [6];
    logic [31:0] ovf_r [6];

    assign aud_bclk    = bclk_r;
    assign aud_adclrck = lrck_r;
    assign aud_daclrck = lrck_r;

    audio_controller #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .XCK_DIV(2)) dut (
        .CLOCK_50               (clk),
        .reset                  (rst_n),
        .clear_audio_in_memory  (clr_in),
        .read_audio_in          (rd_in),
        .clear_audio_out_memory (clr_out),
        .left_channel_audio_out (l_out),
        .right_channel_audio_out(r_out),
        .write_audio_out        (wr_out),
        .AUD_ADCDAT             (adcdat_r),
        .AUD_BCLK               (aud_bclk),
        .AUD_ADCLRCK            (aud_adclrck),
        .AUD_DACLRCK            (aud_daclrck),
        .audio_in_available     (avail),
        .left_channel_audio_in  (l_in),
        .right_channel_audio_in (r_in),
        .audio_out_allowed      (allowed),
        .AUD_XCK                (aud_xck),
        .AUD_DACDAT             (aud_dacdat)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        clr_in  = 1'b0; rd_in = 1'b0; clr_out = 1'b0; wr_out = 1'b0;
        l_out   = '0;   r_out = '0;
        adcdat_r = 1'b0; bclk_r = 1'b1; lrck_r = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // One codec frame: left half (LRCK=1) then right half, 32 BCLKs each, 16 clocks per BCLK
    task automatic codec_frame(input logic [31:0] adc_l, input logic [31:0] adc_r,
                               output logic [31:0] dac_l, output logic [31:0] dac_r);
        dac_l = '0;
        dac_r = '0;
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                bclk_r = 1'b0;
                if (i == 0) lrck_r = (h == 0);
                adcdat_r = (h == 0) ? adc_l[31-i] : adc_r[31-i];
                repeat (8) @(negedge clk);
                bclk_r = 1'b1;
                if (h == 0) dac_l[31-i] = aud_dacdat;
                else        dac_r[31-i] = aud_dacdat;
                repeat (7) @(negedge clk);
            end
        end
    endtask

    // LRCK rise that closes the previous frame so its pair gets pushed
    task automatic lrck_rise();
        @(negedge clk);
        bclk_r = 1'b0; lrck_r = 1'b1; adcdat_r = 1'b0;
        repeat (8) @(negedge clk);
        bclk_r = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_out(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        l_out = l; r_out = r; wr_out = 1'b1;
        @(negedge clk);
        wr_out = 1'b0;
    endtask

    task automatic pop_in();
        @(negedge clk);
        rd_in = 1'b1;
        @(negedge clk);
        rd_in = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        idle_inputs();
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_avail",   32'(avail),      32'd0);
        check_eq("rst_allowed", 32'(allowed),    32'd1);
        check_eq("rst_dacdat",  32'(aud_dacdat), 32'd0);
        check_eq("rst_xck",     32'(aud_xck),    32'd0);
        check_eq("rst_left_in", l_in,            32'd0);
        rst_n = 1'b1;

        n = 0;
        while (aud_xck !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("xck_started", 32'(n < 20), 32'd1);
        @(negedge clk); check_eq("xck_hi2", 32'(aud_xck), 32'd1);
        @(negedge clk); check_eq("xck_lo1", 32'(aud_xck), 32'd0);
        @(negedge clk); check_eq("xck_lo2", 32'(aud_xck), 32'd0);
        @(negedge clk); check_eq("xck_hi1", 32'(aud_xck), 32'd1);

        // ADC capture
        do_reset();
        codec_frame(32'h8000_0001, 32'h1234_5678, dl, dr);
        check_eq("idle_dac_l", dl, 32'd0);
        check_eq("idle_dac_r", dr, 32'd0);
        lrck_rise();
        check_eq("adc_avail", 32'(avail), 32'd1);
        check_eq("adc_left",  l_in, 32'h8000_0001);
        check_eq("adc_right", r_in, 32'h1234_5678);
        pop_in();
        check_eq("adc_avail_after_read", 32'(avail), 32'd0);
        check_eq("adc_left_empty", l_in, 32'd0);

        // DAC playback
        do_reset();
        push_out(32'hA5A5_0000, 32'h0F0F_F0F0);
        check_eq("dac_allowed", 32'(allowed), 32'd1);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("dac_left",  dl, 32'hA5A5_0000);
        check_eq("dac_right", dr, 32'h0F0F_F0F0);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("dac_empty_left",  dl, 32'd0);
        check_eq("dac_empty_right", dr, 32'd0);

        // Output FIFO full, ignored write, write concurrent with pop
        do_reset();
        push_out(32'h1111_0001, 32'h2222_0001);
        push_out(32'h1111_0002, 32'h2222_0002);
        push_out(32'h1111_0003, 32'h2222_0003);
        check_eq("full_allowed_3", 32'(allowed), 32'd1);
        push_out(32'h1111_0004, 32'h2222_0004);
        check_eq("full_allowed_4", 32'(allowed), 32'd0);
        push_out(32'h1111_0005, 32'h2222_0005);
        check_eq("full_allowed_5", 32'(allowed), 32'd0);
        fork
            codec_frame(32'd0, 32'd0, dl, dr);
            begin
                repeat (4) @(negedge clk);
                l_out = 32'h1111_0006; r_out = 32'h2222_0006; wr_out = 1'b1;
                @(negedge clk);
                wr_out = 1'b0;
            end
        join
        check_eq("full_f1_left",  dl, 32'h1111_0001);
        check_eq("full_f1_right", dr, 32'h2222_0001);
        check_eq("full_allowed_after_swap", 32'(allowed), 32'd0);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("full_f2_left",  dl, 32'h1111_0002);
        check_eq("full_f2_right", dr, 32'h2222_0002);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("full_f3_left",  dl, 32'h1111_0003);
        check_eq("full_f3_right", dr, 32'h2222_0003);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("full_f4_left",  dl, 32'h1111_0004);
        check_eq("full_f4_right", dr, 32'h2222_0004);
        codec_frame(32'd0, 32'd0, dl, dr);
        check_eq("full_f5_left",  dl, 32'h1111_0006);
        check_eq("full_f5_right", dr, 32'h2222_0006);
        check_eq("full_drained_allowed", 32'(allowed), 32'd1);

        // Input overflow: pairs 5 and 6 are dropped
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ovf_l[k] = 32'hA000_0000 | 32'(k + 1);
            ovf_r[k] = 32'h0B00_00F0 | 32'(k + 1);
        end
        for (int k = 0; k < 6; k++) codec_frame(ovf_l[k], ovf_r[k], dl, dr);
        lrck_rise();
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("ovf_avail_%0d", k), 32'(avail), 32'd1);
            check_eq($sformatf("ovf_left_%0d", k),  l_in, ovf_l[k]);
            check_eq($sformatf("ovf_right_%0d", k), r_in, ovf_r[k]);
            pop_in();
        end
        check_eq("ovf_avail_end", 32'(avail), 32'd0);

        // Clears win over a same-cycle read and write
        do_reset();
        codec_frame(32'h0000_C001, 32'h0000_D001, dl, dr);
        codec_frame(32'h0000_C002, 32'h0000_D002, dl, dr);
        lrck_rise();
        push_out(32'h0000_E001, 32'h0000_F001);
        push_out(32'h0000_E002, 32'h0000_F002);
        check_eq("clr_pre_avail", 32'(avail), 32'd1);
        check_eq("clr_pre_left",  l_in, 32'h0000_C001);
        @(negedge clk);
        clr_in = 1'b1; clr_out = 1'b1; rd_in = 1'b1; wr_out = 1'b1;
        l_out = 32'h0000_E003; r_out = 32'h0000_F003;
        @(negedge clk);
        clr_in = 1'b0; clr_out = 1'b0; rd_in = 1'b0; wr_out = 1'b0;
        check_eq("clr_avail",   32'(avail),   32'd0);
        check_eq("clr_left",    l_in,         32'd0);
        check_eq("clr_allowed", 32'(allowed), 32'd1);
        push_out(32'h1, 32'h2);
        push_out(32'h3, 32'h4);
        push_out(32'h5, 32'h6);
        check_eq("clr_refill_3", 32'(allowed), 32'd1);
        push_out(32'h7, 32'h8);
        check_eq("clr_refill_4", 32'(allowed), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
